// File: rtl/rk_pkg.sv
// Shared Radio-86RK definitions: tape framing constants and the tape player state encoding.
package rk_pkg;

  localparam logic [7:0] TAPE_SYNC_BYTE    = 8'hE6;
  localparam int         TAPE_LEADER_BYTES = 256;

  typedef enum logic [1:0] {
    TAPE_IDLE   = 2'd0,
    TAPE_LEADER = 2'd1,
    TAPE_SYNC   = 2'd2,
    TAPE_DATA   = 2'd3
  } tape_state_t;

endpackage

// File: rtl/rk_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers, registered full flag and same-cycle (show-ahead) read data.
module rk_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic             full_reg, full_next;
  logic             push, pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = full_reg;
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  // A write into a full FIFO is dropped even if a pop happens on the same cycle.
  assign push    = wr_en && !full_reg;
  assign pop     = rd_en && !empty;

  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      full_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/rk_tape_player.sv
// Radio-86RK tape-in source: leader, sync byte, then FIFO payload, phase-encoded MSB first onto tape_out.
module rk_tape_player
  import rk_pkg::*;
#(
  parameter int         HALF_BIT_CYCLES = 20000,
  parameter int         LEADER_BYTES    = TAPE_LEADER_BYTES,
  parameter logic [7:0] SYNC_BYTE       = TAPE_SYNC_BYTE,
  parameter int         FIFO_DEPTH      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       eof,
  input  logic       start,
  input  logic       abort,
  output logic       full,
  output logic       busy,
  output logic       underrun,
  output logic       tape_out
);
  localparam int TW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int LW = $clog2(LEADER_BYTES) + 1;

  tape_state_t   state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic          half_reg, half_next;
  logic [7:0]    shift_reg, shift_next;
  logic [LW-1:0] leader_cnt_reg, leader_cnt_next;
  logic          tape_reg, tape_next;
  logic          underrun_reg, underrun_next;
  logic          eof_seen_reg, eof_seen_next;

  logic          timer_wrap, end_play, fifo_rd_en, fifo_empty;
  logic [7:0]    next_byte, fifo_rd_data;

  rk_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty),
    .count   ()
  );

  assign busy     = (state_reg != TAPE_IDLE);
  assign underrun = underrun_reg;
  assign tape_out = tape_reg;

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    bit_idx_next    = bit_idx_reg;
    half_next       = half_reg;
    shift_next      = shift_reg;
    leader_cnt_next = leader_cnt_reg;
    tape_next       = tape_reg;
    underrun_next   = underrun_reg;
    eof_seen_next   = eof_seen_reg;
    fifo_rd_en      = 1'b0;
    next_byte       = 8'h00;
    end_play        = 1'b0;
    timer_wrap      = (timer_reg == TW'(HALF_BIT_CYCLES - 1));

    if (state_reg == TAPE_IDLE) begin
      tape_next    = 1'b0;
      timer_next   = '0;
      half_next    = 1'b0;
      bit_idx_next = 3'd7;
      if (start) begin
        // First leader byte begins immediately: its bit7 first half is on the line next edge.
        underrun_next   = 1'b0;
        state_next      = TAPE_LEADER;
        leader_cnt_next = '0;
        shift_next      = next_byte;
        tape_next       = ~next_byte[7];
      end
    end else if (!timer_wrap) begin
      timer_next = timer_reg + TW'(1);
    end else begin
      timer_next = '0;
      if (!half_reg) begin
        half_next = 1'b1;
        tape_next = shift_reg[7];
      end else if (bit_idx_reg != 3'd0) begin
        half_next    = 1'b0;
        bit_idx_next = bit_idx_reg - 3'd1;
        shift_next   = shift_reg << 1;
        tape_next    = ~shift_reg[6];
      end else begin
        // Byte boundary: choose the next byte so the line continues without a gap.
        half_next    = 1'b0;
        bit_idx_next = 3'd7;
        if (state_reg == TAPE_LEADER) begin
          if (leader_cnt_reg == LW'(LEADER_BYTES - 1)) begin
            state_next = TAPE_SYNC;
            next_byte  = SYNC_BYTE;
          end else begin
            leader_cnt_next = leader_cnt_reg + LW'(1);
          end
        end else begin
          state_next = TAPE_DATA;
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            next_byte  = fifo_rd_data;
          end else if (eof_seen_reg) begin
            state_next    = TAPE_IDLE;
            end_play      = 1'b1;
            eof_seen_next = 1'b0;
          end else begin
            underrun_next = 1'b1;
          end
        end
        shift_next = next_byte;
        tape_next  = end_play ? 1'b0 : ~next_byte[7];
      end
    end

    if (eof) begin
      eof_seen_next = 1'b1;
    end

    if (abort) begin
      state_next    = TAPE_IDLE;
      tape_next     = 1'b0;
      timer_next    = '0;
      half_next     = 1'b0;
      bit_idx_next  = 3'd7;
      eof_seen_next = 1'b0;
      underrun_next = underrun_reg;
      fifo_rd_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= TAPE_IDLE;
      timer_reg      <= '0;
      bit_idx_reg    <= 3'd7;
      half_reg       <= 1'b0;
      shift_reg      <= 8'h00;
      leader_cnt_reg <= '0;
      tape_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
      eof_seen_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      bit_idx_reg    <= bit_idx_next;
      half_reg       <= half_next;
      shift_reg      <= shift_next;
      leader_cnt_reg <= leader_cnt_next;
      tape_reg       <= tape_next;
      underrun_reg   <= underrun_next;
      eof_seen_reg   <= eof_seen_next;
    end
  end

endmodule

// File: tb/tb_rk_tape_player.sv
// Directed bench for rk_tape_player with short timing: 4-cycle half-bits, 2 leader bytes, 4-entry FIFO.
module tb_rk_tape_player;
  localparam int HB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       eof = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       full, busy, underrun, tape_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rk_tape_player #(
    .HALF_BIT_CYCLES (HB),
    .LEADER_BYTES    (2),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .eof      (eof),
    .start    (start),
    .abort    (abort),
    .full     (full),
    .busy     (busy),
    .underrun (underrun),
    .tape_out (tape_out)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; wr_en = 1'b0; eof = 1'b0; start = 1'b0; abort = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [7:0] d);
    wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_eof();   eof = 1'b1;   step(); eof = 1'b0;   endtask
  task automatic pulse_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic pulse_abort(); abort = 1'b1; step(); abort = 1'b0; endtask

  // Captures one 16-half byte starting at its first cycle; clean=0 on a glitch or a non-complementary bit.
  task automatic read_byte(output logic [7:0] value, output logic [15:0] halves, output bit clean,
                           input bit push_last, input logic [7:0] push_val);
    logic lvl;
    clean = 1'b1; halves = '0; value = '0;
    for (int h = 0; h < 16; h++) begin
      lvl = tape_out;
      for (int c = 0; c < HB; c++) begin
        if (tape_out !== lvl) clean = 1'b0;
        if (push_last && h == 15 && c == HB - 1) begin
          wr_data = push_val; wr_en = 1'b1;
        end
        step();
      end
      wr_en = 1'b0;
      halves[15-h] = lvl;
    end
    for (int i = 0; i < 8; i++) begin
      value[i] = halves[2*i];
      if (halves[2*i+1] !== ~halves[2*i]) clean = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tape_out, busy, full, underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: tape/busy/full/underrun=%b required 0000", {tape_out, busy, full, underrun});
    end else $display("reset: outputs idle");
  endtask

  task automatic test_basic();
    logic [7:0] exp_q [$];
    logic [7:0] got; logic [15:0] h; bit clean;
    exp_q = '{8'h00, 8'h00, 8'hE6, 8'hA5};
    do_reset();
    push(8'hA5);
    pulse_eof();
    pulse_start();
    foreach (exp_q[i]) begin
      read_byte(got, h, clean, 1'b0, 8'h00);
      checks++;
      if (!clean || got !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h clean=%0d required %h", i, got, clean, exp_q[i]);
      end else $display("basic byte%0d: %h", i, got);
      if (i == 2) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy_mid: busy=%b required 1", busy);
        end
      end
    end
    checks++;
    if (h !== 16'b0110_0110_1001_1001) begin
      errors++;
      $display("FAIL basic_a5_halves: %b required 0110011010011001", h);
    end else $display("basic A5 halves: %b", h);
    checks++;
    if (busy !== 1'b0 || tape_out !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_256: busy=%b tape=%b underrun=%b required 0 0 0", busy, tape_out, underrun);
    end else $display("basic: idle 256 cycles after start");
  endtask

  task automatic test_underrun();
    logic [7:0] exp_q [$];
    logic [7:0] got; logic [15:0] h; bit clean;
    exp_q = '{8'h00, 8'h00, 8'hE6, 8'h00};
    do_reset();
    pulse_start();
    foreach (exp_q[i]) begin
      read_byte(got, h, clean, 1'b0, 8'h00);
      checks++;
      if (!clean || got !== exp_q[i]) begin
        errors++;
        $display("FAIL underrun_byte%0d: got %h clean=%0d required %h", i, got, clean, exp_q[i]);
      end else $display("underrun byte%0d: %h", i, got);
      if (i == 2) begin
        checks++;
        if (underrun !== 1'b1) begin
          errors++;
          $display("FAIL underrun_set: underrun=%b required 1", underrun);
        end
      end
    end
    push(8'h3C);
    pulse_eof();
    repeat (16*HB - 2) step();
    read_byte(got, h, clean, 1'b0, 8'h00);
    checks++;
    if (!clean || got !== 8'h3C) begin
      errors++;
      $display("FAIL underrun_late_byte: got %h clean=%0d required 3c", got, clean);
    end else $display("underrun late byte: %h", got);
    checks++;
    if (busy !== 1'b0 || tape_out !== 1'b0 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_end: busy=%b tape=%b underrun=%b required 0 0 1", busy, tape_out, underrun);
    end else $display("underrun: idle with sticky underrun");
    pulse_start();
    checks++;
    if (underrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL underrun_clear_on_start: underrun=%b busy=%b required 0 1", underrun, busy);
    end else $display("underrun: cleared by start");
    pulse_abort();
  endtask

  task automatic test_full();
    logic [7:0] exp_q [$];
    logic [7:0] got; logic [15:0] h; bit clean;
    exp_q = '{8'h00, 8'h00, 8'hE6, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL full_after_3: full=%b required 0", full);
    end
    push(8'h44);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL full_after_4: full=%b required 1", full);
    end else $display("full: set after 4th push");
    push(8'h55);
    pulse_eof();
    pulse_start();
    foreach (exp_q[i]) begin
      read_byte(got, h, clean, 1'b0, 8'h00);
      checks++;
      if (!clean || got !== exp_q[i]) begin
        errors++;
        $display("FAIL full_byte%0d: got %h clean=%0d required %h", i, got, clean, exp_q[i]);
      end else $display("full byte%0d: %h", i, got);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL full_dropped_5th: busy=%b required 0", busy);
    end else $display("full: 5th byte dropped");
  endtask

  task automatic test_back_to_back();
    logic [7:0] got; logic [15:0] h; bit clean;
    logic [7:0] exp_q [$];
    // Full FIFO: a write on the pop boundary is dropped, so full falls and 8'h99 never plays.
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    pulse_eof();
    pulse_start();
    read_byte(got, h, clean, 1'b0, 8'h00);
    read_byte(got, h, clean, 1'b0, 8'h00);
    read_byte(got, h, clean, 1'b1, 8'h99);
    checks++;
    if (!clean || got !== 8'hE6 || full !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full_boundary: sync=%h full=%b required e6 0", got, full);
    end else $display("b2b full boundary: push dropped, full=0");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[i]) begin
      read_byte(got, h, clean, 1'b0, 8'h00);
      checks++;
      if (!clean || got !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_full_byte%0d: got %h clean=%0d required %h", i, got, clean, exp_q[i]);
      end else $display("b2b full byte%0d: %h", i, got);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full_end: busy=%b required 0", busy);
    end
    // Three queued: simultaneous push and pop keeps the count, and the pushed byte plays last.
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    pulse_eof();
    pulse_start();
    read_byte(got, h, clean, 1'b0, 8'h00);
    read_byte(got, h, clean, 1'b0, 8'h00);
    read_byte(got, h, clean, 1'b1, 8'h77);
    checks++;
    if (!clean || got !== 8'hE6 || full !== 1'b0) begin
      errors++;
      $display("FAIL b2b_boundary: sync=%h full=%b required e6 0", got, full);
    end else $display("b2b boundary: push accepted with pop");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h77};
    foreach (exp_q[i]) begin
      read_byte(got, h, clean, 1'b0, 8'h00);
      checks++;
      if (!clean || got !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h clean=%0d required %h", i, got, clean, exp_q[i]);
      end else $display("b2b byte%0d: %h", i, got);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: busy=%b required 0", busy);
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp_q [$];
    logic [7:0] got; logic [15:0] h; bit clean;
    exp_q = '{8'h00, 8'h00, 8'hE6};
    do_reset();
    push(8'h01); push(8'h02); push(8'h03);
    pulse_start();
    repeat (20) step();
    pulse_abort();
    checks++;
    if ({busy, tape_out, full, underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_state: busy/tape/full/underrun=%b required 0000", {busy, tape_out, full, underrun});
    end else $display("abort: idle next cycle");
    pulse_eof();
    pulse_start();
    foreach (exp_q[i]) begin
      read_byte(got, h, clean, 1'b0, 8'h00);
      checks++;
      if (!clean || got !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_replay_byte%0d: got %h clean=%0d required %h", i, got, clean, exp_q[i]);
      end else $display("abort replay byte%0d: %h", i, got);
    end
    checks++;
    if (busy !== 1'b0 || tape_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_flushed: busy=%b tape=%b required 0 0", busy, tape_out);
    end else $display("abort: FIFO was flushed");
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins: busy=%b required 0", busy);
    end else $display("abort: wins over start");
  endtask

  task automatic test_reset_mid_sync();
    logic [7:0] got; logic [15:0] h; bit clean;
    do_reset();
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    pulse_start();
    read_byte(got, h, clean, 1'b0, 8'h00);
    read_byte(got, h, clean, 1'b0, 8'h00);
    repeat (10) step();
    checks++;
    if (busy !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL rst_precond: busy=%b full=%b required 1 1", busy, full);
    end
    reset_n = 1'b0; start = 1'b1;
    step();
    checks++;
    if ({tape_out, busy, full, underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_sync: tape/busy/full/underrun=%b required 0000", {tape_out, busy, full, underrun});
    end else $display("reset mid sync: outputs at reset values");
    reset_n = 1'b1; start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_ignored: busy=%b required 0", busy);
    end else $display("reset mid sync: start ignored");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_full();
    test_back_to_back();
    test_abort();
    test_reset_mid_sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
